// File: rtl/instruction_decode.sv
// instruction_decode: MIPS decode stage with register file and ID/EX register.
// Define DECODE_BYPASS_EN to forward same-edge writeback data into rs/rt read data.
module instruction_decode #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5
) (
  input  logic                d_clk,
  input  logic                d_rst,
  input  logic                d_i_ce,
  input  logic [IWIDTH-1:0]   d_i_instr,
  input  logic [PC_WIDTH-1:0] d_i_pc,
  input  logic                d_i_stall,
  input  logic                d_i_flush,
  input  logic                d_i_we,
  input  logic [AWIDTH-1:0]   d_i_waddr,
  input  logic [DWIDTH-1:0]   d_i_wdata,
  output logic                d_o_ce,
  output logic [PC_WIDTH-1:0] d_o_pc,
  output logic [5:0]          d_o_opcode,
  output logic [5:0]          d_o_funct,
  output logic [4:0]          d_o_shamt,
  output logic [AWIDTH-1:0]   d_o_rs,
  output logic [AWIDTH-1:0]   d_o_rt,
  output logic [DWIDTH-1:0]   d_o_rs_data,
  output logic [DWIDTH-1:0]   d_o_rt_data,
  output logic [DWIDTH-1:0]   d_o_imm,
  output logic [AWIDTH-1:0]   d_o_waddr,
  output logic                d_o_reg_we
);
  typedef struct packed {
    logic                ce;
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          shamt;
    logic [AWIDTH-1:0]   rs;
    logic [AWIDTH-1:0]   rt;
    logic [DWIDTH-1:0]   rs_data;
    logic [DWIDTH-1:0]   rt_data;
    logic [DWIDTH-1:0]   imm;
    logic [AWIDTH-1:0]   waddr;
    logic                reg_we;
  } idex_t;
  localparam int DEPTH = 2**AWIDTH;
  logic [DWIDTH-1:0] rf_q [DEPTH];
  logic [DWIDTH-1:0] rf_d [DEPTH];
  idex_t idex_q, idex_d, load;
  logic [5:0] op;
  logic [AWIDTH-1:0] rs_a, rt_a, dst;
  logic fwd_rs, fwd_rt, wr;
  assign op   = d_i_instr[31:26];
  assign rs_a = AWIDTH'(d_i_instr[25:21]);
  assign rt_a = AWIDTH'(d_i_instr[20:16]);
  assign wr   = d_i_we && (d_i_waddr != '0);
`ifdef DECODE_BYPASS_EN
  assign fwd_rs = wr && (d_i_waddr == rs_a);
  assign fwd_rt = wr && (d_i_waddr == rt_a);
`else
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
`endif
  always_comb begin
    rf_d = rf_q;
    if (wr) rf_d[d_i_waddr] = d_i_wdata;
  end
  always_comb begin
    dst = (op == 6'h00) ? AWIDTH'(d_i_instr[15:11]) : (op == 6'h03) ? '1 : rt_a;
    load.ce      = 1'b1;
    load.pc      = d_i_pc;
    load.opcode  = op;
    load.funct   = d_i_instr[5:0];
    load.shamt   = d_i_instr[10:6];
    load.rs      = rs_a;
    load.rt      = rt_a;
    load.rs_data = fwd_rs ? d_i_wdata : rf_q[rs_a];
    load.rt_data = fwd_rt ? d_i_wdata : rf_q[rt_a];
    load.imm     = (op >= 6'h0C && op <= 6'h0E) ? DWIDTH'(d_i_instr[15:0]) :
                   (op == 6'h0F) ? DWIDTH'({d_i_instr[15:0], 16'h0000}) :
                   (op == 6'h02 || op == 6'h03) ? DWIDTH'(d_i_instr[25:0]) :
                   {{(DWIDTH-16){d_i_instr[15]}}, d_i_instr[15:0]};
    load.waddr   = dst;
    load.reg_we  = ((op == 6'h00 && d_i_instr[5:0] != 6'h08) || op[5:3] == 3'b001 ||
                    op == 6'h23 || op == 6'h03) && (dst != '0);
    idex_d = idex_q;
    if (d_i_flush || (!d_i_stall && !d_i_ce)) begin
      idex_d.ce     = 1'b0;
      idex_d.reg_we = 1'b0;
    end else if (!d_i_stall) idex_d = load;
  end
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      idex_q <= '0;
    end else begin
      rf_q   <= rf_d;
      idex_q <= idex_d;
    end
  end
  assign d_o_ce      = idex_q.ce;
  assign d_o_pc      = idex_q.pc;
  assign d_o_opcode  = idex_q.opcode;
  assign d_o_funct   = idex_q.funct;
  assign d_o_shamt   = idex_q.shamt;
  assign d_o_rs      = idex_q.rs;
  assign d_o_rt      = idex_q.rt;
  assign d_o_rs_data = idex_q.rs_data;
  assign d_o_rt_data = idex_q.rt_data;
  assign d_o_imm     = idex_q.imm;
  assign d_o_waddr   = idex_q.waddr;
  assign d_o_reg_we  = idex_q.reg_we;
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed and random checks of instruction_decode against a reference model.
module tb_instruction_decode;
  logic        d_clk = 0, d_rst = 0, d_i_ce = 0, d_i_stall = 0, d_i_flush = 0, d_i_we = 0;
  logic [31:0] d_i_instr = 0, d_i_pc = 0, d_i_wdata = 0;
  logic [4:0]  d_i_waddr = 0;
  logic        d_o_ce, d_o_reg_we;
  logic [31:0] d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm;
  logic [5:0]  d_o_opcode, d_o_funct;
  logic [4:0]  d_o_shamt, d_o_rs, d_o_rt, d_o_waddr;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_rf [32];
  logic        e_ce, e_we;
  logic [31:0] e_pc, e_rsd, e_rtd, e_imm;
  logic [5:0]  e_op, e_fn;
  logic [4:0]  e_sh, e_rs, e_rt, e_wa;
  logic [5:0]  ops [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                            6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
  instruction_decode dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce), .d_i_instr(d_i_instr), .d_i_pc(d_i_pc),
    .d_i_stall(d_i_stall), .d_i_flush(d_i_flush), .d_i_we(d_i_we), .d_i_waddr(d_i_waddr),
    .d_i_wdata(d_i_wdata), .d_o_ce(d_o_ce), .d_o_pc(d_o_pc), .d_o_opcode(d_o_opcode),
    .d_o_funct(d_o_funct), .d_o_shamt(d_o_shamt), .d_o_rs(d_o_rs), .d_o_rt(d_o_rt),
    .d_o_rs_data(d_o_rs_data), .d_o_rt_data(d_o_rt_data), .d_o_imm(d_o_imm),
    .d_o_waddr(d_o_waddr), .d_o_reg_we(d_o_reg_we)
  );
  always #5 d_clk = ~d_clk;
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[31:26])
      6'h0C, 6'h0D, 6'h0E: return {16'h0, i[15:0]};
      6'h0F:               return {i[15:0], 16'h0};
      6'h02, 6'h03:        return {6'h0, i[25:0]};
      default:             return 32'($signed(i[15:0]));
    endcase
  endfunction
  function automatic logic [4:0] ref_dst(input logic [31:0] i);
    if (i[31:26] == 6'h00) return i[15:11];
    if (i[31:26] == 6'h03) return 5'd31;
    return i[20:16];
  endfunction
  function automatic logic ref_we(input logic [31:0] i);
    logic w;
    case (i[31:26])
      6'h00:                                           w = (i[5:0] != 6'h08);
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: w = 1;
      6'h23, 6'h03:                                    w = 1;
      default:                                         w = 0;
    endcase
    return w && (ref_dst(i) != 0);
  endfunction
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
`ifdef DECODE_BYPASS_EN
    if (we && wa != 0 && wa == a) return wd;
`endif
    return (a == 0) ? 32'h0 : m_rf[a];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    {e_ce, e_we, e_pc, e_rsd, e_rtd, e_imm, e_op, e_fn, e_sh, e_rs, e_rt, e_wa} = '0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("ce", 32'(d_o_ce), 32'(e_ce));
    chk("pc", d_o_pc, e_pc);
    chk("opcode", 32'(d_o_opcode), 32'(e_op));
    chk("funct", 32'(d_o_funct), 32'(e_fn));
    chk("shamt", 32'(d_o_shamt), 32'(e_sh));
    chk("rs", 32'(d_o_rs), 32'(e_rs));
    chk("rt", 32'(d_o_rt), 32'(e_rt));
    chk("rs_data", d_o_rs_data, e_rsd);
    chk("rt_data", d_o_rt_data, e_rtd);
    chk("imm", d_o_imm, e_imm);
    chk("waddr", 32'(d_o_waddr), 32'(e_wa));
    chk("reg_we", 32'(d_o_reg_we), 32'(e_we));
  endtask
  task automatic step(input logic ce, input logic [31:0] instr, input logic [31:0] pc,
                      input logic stall, input logic flush, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    d_i_ce = ce; d_i_instr = instr; d_i_pc = pc; d_i_stall = stall; d_i_flush = flush;
    d_i_we = we; d_i_waddr = wa; d_i_wdata = wd;
    @(posedge d_clk);
    if (flush || (!stall && !ce)) begin
      e_ce = 0; e_we = 0;
    end else if (!stall) begin
      e_ce = 1; e_pc = pc; e_op = instr[31:26]; e_fn = instr[5:0]; e_sh = instr[10:6];
      e_rs = instr[25:21]; e_rt = instr[20:16];
      e_rsd = ref_read(instr[25:21], we, wa, wd);
      e_rtd = ref_read(instr[20:16], we, wa, wd);
      e_imm = ref_imm(instr); e_wa = ref_dst(instr); e_we = ref_we(instr);
    end
    if (we && wa != 0) m_rf[wa] = wd;
    #1 check_all();
  endtask
  task automatic go(input logic [31:0] instr, input logic [31:0] pc);
    step(1, instr, pc, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] ri;
    model_reset();
    repeat (2) @(posedge d_clk);
    #1 check_all();
    d_rst = 1;
    for (int i = 0; i < 32; i++) step(1, {6'h00, 5'(i), 5'(i), 5'd1, 11'h020}, 32'(i * 4), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5'd8, 32'h0000_1234);
    go(32'h2109_FFFF, 32'd4);
    chk("addi_rs_data", d_o_rs_data, 32'h0000_1234);
    chk("addi_imm", d_o_imm, 32'hFFFF_FFFF);
    go(32'h3509_8000, 32'd8);
    chk("ori_imm", d_o_imm, 32'h0000_8000);
    go(32'h3C09_8000, 32'd12);
    chk("lui_imm", d_o_imm, 32'h8000_0000);
    go(32'h0C00_0010, 32'd16);
    chk("jal_waddr", 32'(d_o_waddr), 32'd31);
    go(32'hAD09_0000, 32'd20);
    chk("sw_reg_we", 32'(d_o_reg_we), 32'd0);
    go(32'h1109_0003, 32'd24);
    go(32'h0800_0040, 32'd28);
    go(32'h0000_0008, 32'd32);
    go(32'h2000_0005, 32'd36);
    go(32'h0022_1820, 32'd40);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h2109_0001 + 32'(k), 32'd100, 1, 0, 0, 0, 0);
      chk("stall_pc_hold", d_o_pc, 32'd40);
    end
    step(1, 32'h2109_0001, 32'd44, 1, 1, 0, 0, 0);
    chk("flush_ce", 32'(d_o_ce), 32'd0);
    step(1, 32'h0022_1820, 32'd48, 0, 0, 1, 5'd1, 32'h0000_AAAA);
`ifdef DECODE_BYPASS_EN
    chk("bypass_rs_data", d_o_rs_data, 32'h0000_AAAA);
`else
    chk("nobypass_rs_data", d_o_rs_data, 32'h0);
`endif
    go(32'h0022_1820, 32'd52);
    chk("r1_written", d_o_rs_data, 32'h0000_AAAA);
    step(1, 32'h0002_1820, 32'd56, 0, 0, 1, 5'd0, 32'h1234_5678);
    chk("r0_zero", d_o_rs_data, 32'h0);
    go(32'h0000_1820, 32'd60);
    chk("r0_still_zero", d_o_rs_data, 32'h0);
    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 15)];
      if (ri[31:26] == 6'h00 && $urandom_range(0, 3) == 0) ri[5:0] = 6'h08;
      step($urandom_range(0, 7) != 0, ri, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
    end
    go(32'h2109_0007, 32'd200);
    d_i_ce = 1; d_i_instr = 32'h2109_0008; d_i_pc = 32'd204;
    d_rst = 0;
    model_reset();
    #1 check_all();
    @(negedge d_clk);
    check_all();
    d_rst = 1;
    go(32'h2109_0009, 32'd208);
    chk("post_reset_ce", 32'(d_o_ce), 32'd1);
    chk("post_reset_pc", d_o_pc, 32'd208);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
